dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words in the data store.
REQ-002 The block SHALL have parameter LAT, default 2, meaning the wait cycles between request capture and response; the legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port re, input, 1 bit: read request strobe from control, held until ready.
REQ-006 The block SHALL have port wr, input, 1 bit: write request strobe from control, held until ready.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address, which is the ALU result.
REQ-008 The block SHALL have port wdata, input, 32 bits: store data.
REQ-009 The block SHALL have port funct3, input, 3 bits: access size and sign, encoded 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 The block SHALL have port rdata, output, 32 bits: load result, extended to 32 bits.
REQ-011 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: fault flag, valid while ready is high.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and RESP.
REQ-014 In IDLE, when re or wr is high on a rising edge, the block SHALL capture addr, wdata and funct3, and SHALL go to BUSY with cnt=LAT-1, or go directly to RESP if LAT=0.
REQ-015 In BUSY, cnt SHALL decrement each cycle; at cnt=0 the next state SHALL be RESP.
REQ-016 In RESP, ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be as follows: with the request sampled at edge N, ready is high in the cycle after edge N+LAT+1.
REQ-018 Request inputs SHALL be ignored outside IDLE; the requester SHALL deassert re/wr in the cycle ready is seen, otherwise a new transaction begins.
REQ-019 The word index SHALL be addr[log2(DEPTH)+1:2] and the byte lane SHALL be addr[1:0].
REQ-020 Out of range, meaning any addr bit at or above log2(DEPTH)+2 is set, SHALL give err=1, rdata=0, and no write.
REQ-021 Misaligned, meaning H/HU with addr[0]=1 or W with addr[1:0]!=0, SHALL give err=1, rdata=0, and no write.
REQ-022 re and wr both high at capture SHALL give err=1 and no write.
REQ-023 An illegal funct3 (011, 110, 111) SHALL give err=1 and no write.
REQ-024 A store SHALL commit on the edge entering RESP, writing only the addressed byte lanes: B writes 1 lane, H writes 2, W writes 4.
REQ-025 A load SHALL register rdata on the edge entering RESP: B/H are sign-extended, BU/HU are zero-extended, W is passed through.
REQ-026 For a store, rdata SHALL be 0.
REQ-027 rdata SHALL hold its value until the next RESP.
REQ-028 A load issued immediately after a store to the same word SHALL return the stored data.

Reset
REQ-029 While reset is high at an edge, the block SHALL set state=IDLE, cnt=0, ready=0, err=0, rdata=0, and clear the captured request.
REQ-030 Reset SHALL take priority over every request.
REQ-031 Reset in BUSY SHALL abort the transaction: no write commits and no ready is issued.
REQ-032 The storage array SHALL NOT be cleared by reset; contents SHALL persist.

Structure
REQ-033 The funct3 encodings and the state enum SHALL live in shared package riscv_pkg.
REQ-034 Lane extract, sign-extension and byte-enable generation SHALL live in one combinational sub-module, dmem_align.
REQ-035 The FSM, counter and storage SHALL reside in dmem_resp.

Verification
REQ-036 With LAT=2, issue SW addr=0x10, wdata=0xDEADBEEF, followed by LW addr=0x10 -> each ready pulse comes 3 cycles after capture; the load returns rdata=0xDEADBEEF, err=0.
REQ-037 After that store, issue SB addr=0x11, wdata=0x000000A5, then LB addr=0x11 and LBU addr=0x11 -> rdata=0xFFFFFFA5 and 0x000000A5 respectively; LW addr=0x10 returns 0xDEADA5EF.
REQ-038 Issue LH addr=0x13 and SW addr=0x102 with DEPTH=64 -> err=1, rdata=0, and a follow-up LW addr=0x10 is unchanged.
REQ-039 Assert re=1 and wr=1 together with addr=0x20 -> err=1 at ready; word 0x20 is unmodified.
REQ-040 Issue SW addr=0x30, wdata=0x12345678, and assert reset in the first BUSY cycle -> no ready pulse; a later LW addr=0x30 returns the prior contents.
REQ-041 With LAT=0, hold re high continuously on LW addr=0x10 -> ready pulses every 2 cycles with constant rdata.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory response path.
// Holds the funct3 access encodings, the FSM state enum and the captured-request record.
// No logic of its own. Imported by dmem_align and dmem_resp.
package riscv_pkg;

    // funct3 access size / sign encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Request as captured from the control path in IDLE
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment for a 32-bit data memory: store byte enables and lane-replicated
// store data, load lane extract with sign/zero extension, misalign and illegal-funct3 flags.
// Latency: purely combinational. Backpressure: none.
// Ports: funct3/lane select the access; wdata is store data; rword is the addressed memory
// word; be/wword drive the write port; rdata is the extended load value; misalign/illegal
// flag faults the caller must act on (outputs here are not gated by the faults).
module dmem_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0 so every size extracts from the bottom
    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        be       = 4'b0000;
        wword    = wdata;
        rdata    = 32'd0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                rdata = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'd0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misalign = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'd0, shifted[15:0]};
            end
            F3_W: begin
                misalign = |lane;
                be       = 4'b1111;
                // lane is 0 whenever the word access is legal, so shifted == rword
                rdata    = shifted;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data memory with fixed response latency and byte/half/word access.
// Latency: request captured at edge N, ready high in the cycle after edge N+LAT+1.
// Backpressure: none; re/wr are held until ready and ignored outside IDLE.
// Ports: clk, reset (sync, active high); re/wr request strobes; addr byte address;
// wdata store data; funct3 access size/sign; rdata load result; ready one-cycle
// completion pulse; err fault flag valid with ready. LAT legal range is 0..15.
module dmem_resp
    import riscv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    dmem_state_t state;
    logic [3:0]  cnt;
    dmem_req_t   req;
    logic [31:0] mem [0:DEPTH-1];

    dmem_req_t   cur;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword;
    logic [31:0] ext;
    logic        misalign;
    logic        illegal;
    logic        oor;
    logic        fault;
    logic        enter_resp;

    // With LAT=0 RESP is entered on the capture edge itself, before req is
    // registered, so the commit path looks at the live inputs while in IDLE.
    always_comb begin
        cur = req;
        if (state == IDLE) begin
            cur.rd     = re;
            cur.wr     = wr;
            cur.addr   = addr;
            cur.wdata  = wdata;
            cur.funct3 = funct3;
        end
    end

    assign idx   = cur.addr[AW+1:2];
    assign oor   = |(cur.addr >> (AW + 2));
    assign fault = oor | misalign | illegal | (cur.rd & cur.wr);

    assign enter_resp = ((state == IDLE) && (re || wr) && (LAT == 0)) ||
                        ((state == BUSY) && (cnt == 4'd0));

    dmem_align u_align (
        .funct3   (cur.funct3),
        .lane     (cur.addr[1:0]),
        .wdata    (cur.wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wword    (wword),
        .rdata    (ext),
        .misalign (misalign),
        .illegal  (illegal)
    );

    // ready is registered from the RESP state, so the pulse lands the cycle after
    // RESP while the FSM is already back in IDLE; rdata/err are loaded one edge earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
            req   <= '0;
        end else begin
            ready <= (state == RESP);
            case (state)
                IDLE: begin
                    if (re || wr) begin
                        req.rd     <= re;
                        req.wr     <= wr;
                        req.addr   <= addr;
                        req.wdata  <= wdata;
                        req.funct3 <= funct3;
                        cnt        <= CNT_INIT;
                        state      <= (LAT == 0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (enter_resp) begin
                err   <= fault;
                rdata <= (cur.rd && !cur.wr && !fault) ? ext : 32'd0;
            end
        end
    end

    // Storage has no reset so contents survive it; a reset at the commit edge
    // suppresses the write along with the rest of the transaction.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur.wr && !cur.rd && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        reset;
    logic        re, wr;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        ready, err;

    logic        re0, wr0;
    logic [31:0] addr0, wdata0;
    logic [2:0]  funct30;
    logic [31:0] rdata0;
    logic        ready0, err0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        re;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    dmem_resp #(.DEPTH(64), .LAT(2)) dut (
        .clk(clk), .reset(reset), .re(re), .wr(wr), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .ready(ready), .err(err)
    );

    dmem_resp #(.DEPTH(64), .LAT(0)) dut0 (
        .clk(clk), .reset(reset), .re(re0), .wr(wr0), .addr(addr0), .wdata(wdata0),
        .funct3(funct30), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.re = r; v.wr = w; v.addr = a; v.wdata = d; v.f3 = f;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // One transaction on the LAT=2 instance: hold request until ready, check result,
    // latency (3 cycles after the capture edge) and that ready lasts one cycle.
    task automatic run_txn(input vec_t v, input string id);
        int   cyc;
        bit   got;
        exp_t e;
        @(negedge clk);
        re = v.re; wr = v.wr; addr = v.addr; wdata = v.wdata; funct3 = v.f3;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready) got = 1;
        end
        re = 1'b0;
        wr = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no ready after %0d cycles, required within 20", id, cyc);
        end else begin
            chk({id, " rdata"}, rdata, e.rdata);
            chk({id, " err"}, {31'd0, err}, {31'd0, e.err});
            chk({id, " latency"}, 32'(cyc - 1), 32'd3);
            @(posedge clk);
            @(negedge clk);
            chk({id, " ready_width"}, {31'd0, ready}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        int cyc;
        bit got;

        re = 0; wr = 0; addr = 0; wdata = 0; funct3 = W;
        re0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; funct30 = W;

        // Reset with a request pending: reset must win, nothing may start
        reset = 1'b1;
        re = 1'b1; addr = 32'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        re = 1'b0;
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready) pulses++;
        end
        chk("reset priority no ready", pulses, 32'd0);

        //        re    wr    addr         wdata         f3   exp_rdata     err
        vecs.push_back(mk(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, W,   32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        W,   32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h11,  32'h000000A5, B,   32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h11,  32'h0,        B,   32'hFFFFFFA5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h11,  32'h0,        BU,  32'h000000A5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        W,   32'hDEADA5EF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h13,  32'h0,        H,   32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h102, 32'hFFFFFFFF, W,   32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        W,   32'hDEADA5EF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h20,  32'h55AA1234, W,   32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h20,  32'hFFFFFFFF, W,   32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h20,  32'h0,        W,   32'h55AA1234, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h12,  32'h0,        H,   32'hFFFFDEAD, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h12,  32'h0,        HU,  32'h0000DEAD, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        H,   32'hFFFFA5EF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h13,  32'h0,        B,   32'hFFFFFFDE, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        BU,  32'h000000EF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14,  32'h11223344, W,   32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h16,  32'h0000BEEF, H,   32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,  32'h0,        W,   32'hBEEF3344, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14,  32'h0,        3'b011, 32'h0,     1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h15,  32'h0,        W,   32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h17,  32'h0,        H,   32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,  32'h0,        W,   32'hBEEF3344, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h00,  32'h01020304, W,   32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, W,   32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00,  32'h0,        W,   32'h01020304, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        3'b110, 32'h0,     1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0,        W,   32'hDEADA5EF, 1'b0));

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // rdata holds between transactions
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rdata hold", rdata, 32'hDEADA5EF);

        // Reset during BUSY aborts a store
        run_txn(mk(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, W, 32'h0, 1'b0), "pre30");
        @(negedge clk);
        wr = 1'b1; addr = 32'h30; wdata = 32'h12345678; funct3 = W;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort rdata cleared", rdata, 32'd0);
        chk("abort err cleared", {31'd0, err}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (ready) pulses++;
        end
        chk("abort no ready", pulses, 32'd0);
        run_txn(mk(1'b1, 1'b0, 32'h30, 32'h0, W, 32'hCAFEF00D, 1'b0), "post30");

        // LAT=0 instance: store, then hold a load request continuously
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h0BADCAFE; funct30 = W;
        cyc = 0;
        got = 0;
        while (!got && cyc < 10) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (ready0) got = 1;
        end
        wr0 = 1'b0;
        chk("lat0 store ready", {31'd0, got}, 32'd1);
        chk("lat0 store latency", cyc, 32'd2);
        @(posedge clk);
        @(negedge clk);
        re0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("lat0 ready[%0d]", i), {31'd0, ready0}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (ready0) begin
                chk($sformatf("lat0 rdata[%0d]", i), rdata0, 32'h0BADCAFE);
                chk($sformatf("lat0 err[%0d]", i), {31'd0, err0}, 32'd0);
            end
        end
        re0 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
